// File: rtl/fft_r4_stage_scheduler.sv
// -----------------------------------------------------------------------------
// fft_r4_stage_scheduler
//
// Address/control sequencer for an in-place radix-4 decimation-in-frequency FFT
// of N = 4^LOG4N complex points built around one shared radix-4 butterfly with
// a fixed pipeline latency of BF_LATENCY cycles.
//
// For every butterfly the block issues four read addresses plus a twiddle base
// exponent. BF_LATENCY cycles later it issues the matching in-place write-back
// addresses. It steps through all LOG4N stages and drains the butterfly
// pipeline between stages, so the last write of a stage lands one cycle before
// the first read of the next stage.
//
// Optional feature macro: FFT_SCHED_DIGITREV_EN
//   When defined, an UNLOAD phase follows the final drain. It emits N readout
//   addresses in base-4 digit-reversed order, which yields natural-order
//   output. When undefined, the ro_* ports and the UNLOAD state do not exist.
//
// Parameters
//   LOG4N       number of radix-4 stages (1..4), N = 4^LOG4N
//   BF_LATENCY  butterfly input-to-result latency in cycles (1..8)
//
// Ports
//   sys_clk_i   clock, rising edge
//   rst_n_i     asynchronous active-low reset; clears every register
//   start_i     run request, sampled only while idle
//   busy_o      high from the first issue cycle until completion
//   done_o      one-cycle completion pulse
//   rd_en_o     butterfly input valid / RAM read strobe
//   rd_addr_o   four read addresses, leg m at [m*AW +: AW]
//   tw_exp_o    twiddle base exponent k (leg m uses W_N^(m*k))
//   stage_o     stage index of the current issue
//   wr_en_o     write-back strobe (rd_en_o delayed by BF_LATENCY)
//   wr_addr_o   write-back addresses (rd_addr_o delayed by BF_LATENCY)
//   ro_en_o     readout strobe            (FFT_SCHED_DIGITREV_EN only)
//   ro_addr_o   readout address           (FFT_SCHED_DIGITREV_EN only)
// -----------------------------------------------------------------------------
module fft_r4_stage_scheduler #(
  parameter int LOG4N      = 2,
  parameter int BF_LATENCY = 2,
  localparam int AW        = 2 * LOG4N,
  localparam int SW        = 2
) (
  input  logic              sys_clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [4*AW-1:0]   rd_addr_o,
  output logic [AW-1:0]     tw_exp_o,
  output logic [SW-1:0]     stage_o,
  output logic              wr_en_o,
  output logic [4*AW-1:0]   wr_addr_o
`ifdef FFT_SCHED_DIGITREV_EN
  ,
  output logic              ro_en_o,
  output logic [AW-1:0]     ro_addr_o
`endif
);

  localparam int N   = 1 << AW;
  // Intermediate address arithmetic is done two bits wider and then truncated,
  // so all results wrap modulo 2^AW.
  localparam int AW2 = AW + 2;

  localparam logic [AW-1:0] B_LAST = AW'(N / 4 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG4N - 1);
  localparam logic [3:0]    D_LAST = 4'(BF_LATENCY - 1);
`ifdef FFT_SCHED_DIGITREV_EN
  localparam logic [AW-1:0] J_LAST = AW'(N - 1);
`endif

  // ---------------------------------------------------------------------------
  // Address helpers
  // ---------------------------------------------------------------------------

  // Four leg addresses of butterfly b in stage s:
  //   span = 4^(LOG4N-1-s), k = b mod span,
  //   base = (b/span)*4*span + k, leg m = base + m*span.
  // span is a power of four, so the divide and modulo reduce to shift/mask.
  function automatic logic [4*AW-1:0] leg_addrs(input logic [SW-1:0] s,
                                                input logic [AW-1:0] b);
    logic [AW2-1:0]  span;
    logic [AW2-1:0]  k;
    logic [AW2-1:0]  base;
    logic [AW2-1:0]  leg;
    logic [4*AW-1:0] res;
    int              sh;
    sh   = 2 * (LOG4N - 1 - int'(s));
    span = AW2'(1) << sh;
    k    = {2'b00, b} & (span - AW2'(1));
    base = (({2'b00, b} >> sh) << (sh + 2)) | k;
    res  = '0;
    for (int m = 0; m < 4; m++) begin
      leg = base + span * AW2'(m);
      res[m*AW +: AW] = AW'(leg);
    end
    return res;
  endfunction

  // Twiddle base exponent k * 4^s, wrapped to AW bits.
  function automatic logic [AW-1:0] tw_exp(input logic [SW-1:0] s,
                                           input logic [AW-1:0] b);
    logic [AW2-1:0] span;
    logic [AW2-1:0] k;
    logic [AW2-1:0] t;
    int             sh;
    sh   = 2 * (LOG4N - 1 - int'(s));
    span = AW2'(1) << sh;
    k    = {2'b00, b} & (span - AW2'(1));
    t    = k << (2 * int'(s));
    return AW'(t);
  endfunction

`ifdef FFT_SCHED_DIGITREV_EN
  // Base-4 digit reversal: digit d of the result is digit LOG4N-1-d of j.
  function automatic logic [AW-1:0] digit_rev(input logic [AW-1:0] j);
    logic [AW-1:0] r;
    r = '0;
    for (int d = 0; d < LOG4N; d++) begin
      r[2*d +: 2] = j[2*(LOG4N-1-d) +: 2];
    end
    return r;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
`ifdef FFT_SCHED_DIGITREV_EN
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, UNLOAD} state_e;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
`endif

  state_e            state_q;
  logic [SW-1:0]     s_q;
  logic [AW-1:0]     b_q;
  logic [3:0]        drain_q;

  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [4*AW-1:0]   rd_addr_q;
  logic [AW-1:0]     tw_q;
  logic [SW-1:0]     stage_q;

`ifdef FFT_SCHED_DIGITREV_EN
  logic [AW-1:0]     j_q;
  logic [AW-1:0]     j_d;
  logic              ro_en_q;
  logic [AW-1:0]     ro_addr_q;
`endif

  // Next-issue candidates: the following butterfly within the current stage,
  // and butterfly 0 of the following stage.
  logic [AW-1:0]     b_d;
  logic [SW-1:0]     s_d;
  logic [4*AW-1:0]   addr_b_d;
  logic [AW-1:0]     tw_b_d;
  logic [4*AW-1:0]   addr_s_d;

  always_comb begin
    b_d      = b_q + AW'(1);
    s_d      = s_q + SW'(1);
    addr_b_d = leg_addrs(s_q, b_d);
    tw_b_d   = tw_exp(s_q, b_d);
    addr_s_d = leg_addrs(s_d, '0);
  end

`ifdef FFT_SCHED_DIGITREV_EN
  always_comb begin
    j_d = j_q + AW'(1);
  end
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs. Outputs are loaded together with the
  // state transition, so the first issue appears the cycle after start_i.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      s_q       <= '0;
      b_q       <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tw_q      <= '0;
      stage_q   <= '0;
`ifdef FFT_SCHED_DIGITREV_EN
      j_q       <= '0;
      ro_en_q   <= 1'b0;
      ro_addr_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= ISSUE;
            s_q       <= '0;
            b_q       <= '0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= leg_addrs('0, '0);
            tw_q      <= '0;
            stage_q   <= '0;
          end
        end

        ISSUE: begin
          if (b_q == B_LAST) begin
            state_q <= DRAIN;
            drain_q <= '0;
            rd_en_q <= 1'b0;
          end else begin
            b_q       <= b_d;
            rd_addr_q <= addr_b_d;
            tw_q      <= tw_b_d;
          end
        end

        DRAIN: begin
          // Hold off reads until every result of this stage is written back.
          if (drain_q == D_LAST) begin
            if (s_q != S_LAST) begin
              state_q   <= ISSUE;
              s_q       <= s_d;
              b_q       <= '0;
              rd_en_q   <= 1'b1;
              rd_addr_q <= addr_s_d;
              tw_q      <= '0;
              stage_q   <= s_d;
            end else begin
`ifdef FFT_SCHED_DIGITREV_EN
              state_q   <= UNLOAD;
              j_q       <= '0;
              ro_en_q   <= 1'b1;
              ro_addr_q <= digit_rev('0);
`else
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              stage_q   <= '0;
`endif
            end
          end else begin
            drain_q <= drain_q + 4'd1;
          end
        end

`ifdef FFT_SCHED_DIGITREV_EN
        UNLOAD: begin
          if (j_q == J_LAST) begin
            state_q   <= IDLE;
            ro_en_q   <= 1'b0;
            ro_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            stage_q   <= '0;
          end else begin
            j_q       <= j_d;
            ro_addr_q <= digit_rev(j_d);
          end
        end
`endif

        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back delay line: the write side is simply the read side delayed by
  // the butterfly latency, so writes can never drift from their reads. It is
  // cleared by reset so no stale write escapes after a mid-run reset.
  // ---------------------------------------------------------------------------
  logic [BF_LATENCY-1:0]            en_dly_q;
  logic [BF_LATENCY-1:0][4*AW-1:0]  addr_dly_q;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_dly_q   <= '0;
      addr_dly_q <= '0;
    end else begin
      en_dly_q[0]   <= rd_en_q;
      addr_dly_q[0] <= rd_addr_q;
      for (int i = 1; i < BF_LATENCY; i++) begin
        en_dly_q[i]   <= en_dly_q[i-1];
        addr_dly_q[i] <= addr_dly_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all driven straight from registers)
  // ---------------------------------------------------------------------------
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign tw_exp_o  = tw_q;
  assign stage_o   = stage_q;
  assign wr_en_o   = en_dly_q[BF_LATENCY-1];
  assign wr_addr_o = addr_dly_q[BF_LATENCY-1];
`ifdef FFT_SCHED_DIGITREV_EN
  assign ro_en_o   = ro_en_q;
  assign ro_addr_o = ro_addr_q;
`endif

endmodule

// File: tb/tb_fft_r4_stage_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for fft_r4_stage_scheduler.
// DUT A: LOG4N=2 (N=16), BF_LATENCY=2.  DUT B: LOG4N=3 (N=64), BF_LATENCY=1.
// Cycle 0 is the cycle in which start is held high while the DUT is idle.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_fft_r4_stage_scheduler;

`ifdef FFT_SCHED_DIGITREV_EN
  localparam int DONE_A = 29;
  localparam int DONE_B = 116;
`else
  localparam int DONE_A = 13;
  localparam int DONE_B = 52;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a;
  logic start_b;

  logic        busy_a, done_a, rd_en_a, wr_en_a;
  logic [15:0] rd_addr_a, wr_addr_a;
  logic [3:0]  tw_a;
  logic [1:0]  stage_a;

  logic        busy_b, done_b, rd_en_b, wr_en_b;
  logic [23:0] rd_addr_b, wr_addr_b;
  logic [5:0]  tw_b;
  logic [1:0]  stage_b;

`ifdef FFT_SCHED_DIGITREV_EN
  logic        ro_en_a, ro_en_b;
  logic [3:0]  ro_addr_a;
  logic [5:0]  ro_addr_b;
  logic [3:0]  rev_tab [16] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1, 4'd5, 4'd9, 4'd13,
                                4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15};
`endif

  int errors = 0;
  int checks = 0;

  fft_r4_stage_scheduler #(.LOG4N(2), .BF_LATENCY(2)) dut_a (
    .sys_clk_i (clk),
    .rst_n_i   (rst_n),
    .start_i   (start_a),
    .busy_o    (busy_a),
    .done_o    (done_a),
    .rd_en_o   (rd_en_a),
    .rd_addr_o (rd_addr_a),
    .tw_exp_o  (tw_a),
    .stage_o   (stage_a),
    .wr_en_o   (wr_en_a),
    .wr_addr_o (wr_addr_a)
`ifdef FFT_SCHED_DIGITREV_EN
    ,
    .ro_en_o   (ro_en_a),
    .ro_addr_o (ro_addr_a)
`endif
  );

  fft_r4_stage_scheduler #(.LOG4N(3), .BF_LATENCY(1)) dut_b (
    .sys_clk_i (clk),
    .rst_n_i   (rst_n),
    .start_i   (start_b),
    .busy_o    (busy_b),
    .done_o    (done_b),
    .rd_en_o   (rd_en_b),
    .rd_addr_o (rd_addr_b),
    .tw_exp_o  (tw_b),
    .stage_o   (stage_b),
    .wr_en_o   (wr_en_b),
    .wr_addr_o (wr_addr_b)
`ifdef FFT_SCHED_DIGITREV_EN
    ,
    .ro_en_o   (ro_en_b),
    .ro_addr_o (ro_addr_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived issue table for N=16: stage 0 in cycles 1..4, stage 1 in 7..10.
  function automatic void exp_a(input int c, output logic en, output logic [15:0] addr,
                                output logic [3:0] tw, output logic [1:0] st);
    int b;
    en = 1'b0; addr = '0; tw = '0; st = '0;
    if (c >= 1 && c <= 4) begin
      b = c - 1;
      en = 1'b1; tw = 4'(b); st = 2'd0;
      addr = {4'(b + 12), 4'(b + 8), 4'(b + 4), 4'(b)};
    end else if (c >= 7 && c <= 10) begin
      b = c - 7;
      en = 1'b1; tw = 4'd0; st = 2'd1;
      addr = {4'(4*b + 3), 4'(4*b + 2), 4'(4*b + 1), 4'(4*b)};
    end
  endfunction

  // N=64, latency 1: stage s issues in cycles 1+17s .. 16+17s.
  function automatic logic exp_en_b(input int c);
    logic en;
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (c >= 1 + 17*s && c <= 16 + 17*s) en = 1'b1;
    end
    return en;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    tick(); tick();
    checks++;
    if ({busy_a, done_a, rd_en_a, wr_en_a} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl_a got=%b exp=0000", {busy_a, done_a, rd_en_a, wr_en_a});
    end
    checks++;
    if ({rd_addr_a, wr_addr_a, tw_a, stage_a} !== 38'd0) begin
      errors++; $display("FAIL reset_data_a got=%h exp=0", {rd_addr_a, wr_addr_a, tw_a, stage_a});
    end
    checks++;
    if ({busy_b, done_b, rd_en_b, wr_en_b, rd_addr_b, wr_addr_b, tw_b, stage_b} !== 62'd0) begin
      errors++; $display("FAIL reset_b got=%h exp=0",
                         {busy_b, done_b, rd_en_b, wr_en_b, rd_addr_b, wr_addr_b, tw_b, stage_b});
    end
`ifdef FFT_SCHED_DIGITREV_EN
    checks++;
    if ({ro_en_a, ro_addr_a} !== 5'd0) begin
      errors++; $display("FAIL reset_ro_a got=%h exp=0", {ro_en_a, ro_addr_a});
    end
`endif
    rst_n = 1'b1;
    tick();
    $display("test_reset: reset state examined");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_default_run();
    logic        en, wen;
    logic [15:0] addr, waddr;
    logic [3:0]  tw, wtw;
    logic [1:0]  st, wst;
    int          nwr;
    nwr = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= DONE_A; c++) begin
      exp_a(c, en, addr, tw, st);
      checks++;
      if (rd_en_a !== en) begin
        errors++; $display("FAIL run_rd_en c=%0d got=%b exp=%b", c, rd_en_a, en);
      end
      if (en) begin
        checks++;
        if ({rd_addr_a, tw_a, stage_a} !== {addr, tw, st}) begin
          errors++; $display("FAIL run_issue c=%0d got addr=%h tw=%0d st=%0d exp addr=%h tw=%0d st=%0d",
                             c, rd_addr_a, tw_a, stage_a, addr, tw, st);
        end
        $display("issue c=%0d stage=%0d addr=%h tw=%0d", c, stage_a, rd_addr_a, tw_a);
      end
      exp_a(c - 2, wen, waddr, wtw, wst);
      checks++;
      if (wr_en_a !== wen) begin
        errors++; $display("FAIL run_wr_en c=%0d got=%b exp=%b", c, wr_en_a, wen);
      end
      if (wen) begin
        checks++;
        if (wr_addr_a !== waddr) begin
          errors++; $display("FAIL run_wr_addr c=%0d got=%h exp=%h", c, wr_addr_a, waddr);
        end
      end
      if (wr_en_a === 1'b1) nwr++;
      checks++;
      if ({busy_a, done_a} !== {(c < DONE_A), (c == DONE_A)}) begin
        errors++; $display("FAIL run_busy_done c=%0d got=%b%b exp=%b%b",
                           c, busy_a, done_a, (c < DONE_A), (c == DONE_A));
      end
`ifdef FFT_SCHED_DIGITREV_EN
      checks++;
      if (ro_en_a !== (c >= 13 && c <= 28)) begin
        errors++; $display("FAIL run_ro_en c=%0d got=%b exp=%b", c, ro_en_a, (c >= 13 && c <= 28));
      end
      if (c >= 13 && c <= 28) begin
        checks++;
        if (ro_addr_a !== rev_tab[c-13]) begin
          errors++; $display("FAIL run_ro_addr c=%0d got=%0d exp=%0d", c, ro_addr_a, rev_tab[c-13]);
        end
      end
`endif
      if (c < DONE_A) tick();
    end
    checks++;
    if (nwr !== 8) begin
      errors++; $display("FAIL run_wr_count got=%0d exp=8", nwr);
    end
    tick();
    checks++;
    if ({busy_a, done_a, rd_en_a} !== 3'b000) begin
      errors++; $display("FAIL run_after_done got=%b exp=000", {busy_a, done_a, rd_en_a});
    end
    $display("test_default_run: run finished, writes=%0d", nwr);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_start_held();
    logic        en;
    logic [15:0] addr;
    logic [3:0]  tw;
    logic [1:0]  st;
    int          r;
    start_a = 1'b1;
    tick();
    for (int c = 1; c <= 2*DONE_A; c++) begin
      r = (c <= DONE_A) ? c : c - DONE_A;
      exp_a(r, en, addr, tw, st);
      checks++;
      if (rd_en_a !== en) begin
        errors++; $display("FAIL held_rd_en c=%0d got=%b exp=%b", c, rd_en_a, en);
      end
      if (en) begin
        checks++;
        if (rd_addr_a !== addr) begin
          errors++; $display("FAIL held_rd_addr c=%0d got=%h exp=%h", c, rd_addr_a, addr);
        end
      end
      checks++;
      if ({busy_a, done_a} !== {(r != DONE_A), (r == DONE_A)}) begin
        errors++; $display("FAIL held_busy_done c=%0d got=%b%b exp=%b%b",
                           c, busy_a, done_a, (r != DONE_A), (r == DONE_A));
      end
      if (c == DONE_A + 1) start_a = 1'b0;
      if (c < 2*DONE_A) tick();
    end
    tick();
    checks++;
    if ({busy_a, rd_en_a} !== 2'b00) begin
      errors++; $display("FAIL held_no_third_run got=%b exp=00", {busy_a, rd_en_a});
    end
    $display("test_start_held: two back-to-back runs finished");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midrun();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 2; c <= 8; c++) tick();
    checks++;
    if (rd_en_a !== 1'b1) begin
      errors++; $display("FAIL midrun_active got=%b exp=1", rd_en_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, rd_en_a, wr_en_a, rd_addr_a, wr_addr_a, tw_a, stage_a} !== 42'd0) begin
      errors++; $display("FAIL midrun_async_clear got=%h exp=0",
                         {busy_a, done_a, rd_en_a, wr_en_a, rd_addr_a, wr_addr_a, tw_a, stage_a});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({busy_a, done_a, rd_en_a, wr_en_a} !== 4'b0) begin
        errors++; $display("FAIL midrun_quiet i=%0d got=%b exp=0000", i, {busy_a, done_a, rd_en_a, wr_en_a});
      end
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= DONE_A; c++) begin
      checks++;
      if (done_a !== (c == DONE_A)) begin
        errors++; $display("FAIL midrun_restart_done c=%0d got=%b exp=%b", c, done_a, (c == DONE_A));
      end
      if (c < DONE_A) tick();
    end
    tick();
    $display("test_reset_midrun: restart after reset finished");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_log4n3();
    logic        en;
    logic        chk;
    logic [23:0] addr;
    logic [5:0]  tw;
    logic [1:0]  st;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= DONE_B; c++) begin
      en = exp_en_b(c);
      checks++;
      if (rd_en_b !== en) begin
        errors++; $display("FAIL n64_rd_en c=%0d got=%b exp=%b", c, rd_en_b, en);
      end
      checks++;
      if (wr_en_b !== exp_en_b(c - 1)) begin
        errors++; $display("FAIL n64_wr_en c=%0d got=%b exp=%b", c, wr_en_b, exp_en_b(c - 1));
      end
      chk = 1'b1; addr = '0; tw = '0; st = '0;
      case (c)
        1:  begin addr = {6'd48, 6'd32, 6'd16, 6'd0};  tw = 6'd0;  st = 2'd0; end
        2:  begin addr = {6'd49, 6'd33, 6'd17, 6'd1};  tw = 6'd1;  st = 2'd0; end
        16: begin addr = {6'd63, 6'd47, 6'd31, 6'd15}; tw = 6'd15; st = 2'd0; end
        18: begin addr = {6'd12, 6'd8,  6'd4,  6'd0};  tw = 6'd0;  st = 2'd1; end
        23: begin addr = {6'd29, 6'd25, 6'd21, 6'd17}; tw = 6'd4;  st = 2'd1; end
        38: begin addr = {6'd15, 6'd14, 6'd13, 6'd12}; tw = 6'd0;  st = 2'd2; end
        default: chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if ({rd_addr_b, tw_b, stage_b} !== {addr, tw, st}) begin
          errors++; $display("FAIL n64_issue c=%0d got addr=%h tw=%0d st=%0d exp addr=%h tw=%0d st=%0d",
                             c, rd_addr_b, tw_b, stage_b, addr, tw, st);
        end
        $display("n64 issue c=%0d stage=%0d addr=%h tw=%0d", c, stage_b, rd_addr_b, tw_b);
      end
      if (c == 3) begin
        checks++;
        if (wr_addr_b !== {6'd49, 6'd33, 6'd17, 6'd1}) begin
          errors++; $display("FAIL n64_wr_addr c=%0d got=%h exp=%h", c, wr_addr_b, {6'd49, 6'd33, 6'd17, 6'd1});
        end
      end
`ifdef FFT_SCHED_DIGITREV_EN
      if (c == 53 || c == 58) begin
        checks++;
        if ({ro_en_b, ro_addr_b} !== {1'b1, (c == 53) ? 6'd16 : 6'd36}) begin
          errors++; $display("FAIL n64_ro c=%0d got=%b/%0d", c, ro_en_b, ro_addr_b);
        end
      end
`endif
      checks++;
      if (done_b !== (c == DONE_B)) begin
        errors++; $display("FAIL n64_done c=%0d got=%b exp=%b", c, done_b, (c == DONE_B));
      end
      if (c < DONE_B) tick();
    end
    $display("test_log4n3: N=64 run finished");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    test_reset();
    test_default_run();
    test_start_held();
    test_reset_midrun();
    test_log4n3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
